stage_skid_reg: RTL and testbench
=================================

Name: stage_skid_reg

Overview:
- Parametrised successor to the fixed-width IF-to-EXE pipeline register.
- Carries instruction, PC and a packed control word between two pipeline stages using valid/ready handshakes.
- Contains a 2-entry skid buffer, so upstream ready is registered.
- Supports flush (bubble insertion) and counts downstream stall cycles.
- Sits between fetch/decode and execute; also reusable at any other stage boundary.

Parameters:
INSN_W, 32, instruction width
PC_W, 14, PC width
CTRL_W, 13, packed control width (B_sel 1, ALU_sel 4, Reg_WE 1, DMEM_sel 2, LOAD_sel 3, WB_sel 2)
NOP_INSN, 32'h00000013, instruction driven when out_valid=0 (addi x0,x0,0)
STALL_CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream presents a transfer
in_ready  out  1  block can accept; registered
in_insn  in  INSN_W  upstream instruction
in_pc  in  PC_W  upstream PC
in_ctrl  in  CTRL_W  upstream control word
flush  in  1  synchronous kill of all held entries
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts
out_insn  out  INSN_W  held instruction
out_pc  out  PC_W  held PC
out_ctrl  out  CTRL_W  held control word
skid_full  out  1  skid entry occupied
stall_cnt  out  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Handshakes:
  - acc = in_valid & in_ready; drn = out_valid & out_ready.
  - Entries: main (drives out_*) and skid. in_ready = ~skid_valid, registered.
  - out_valid = main_valid.
- Reset (rst=1 at a rising edge), outputs after that edge:
  - out_valid=0, skid_full=0, in_ready=1, stall_cnt=0
  - out_insn=NOP_INSN, out_pc=0, out_ctrl=0; skid contents cleared.
  - Reset dominates flush and all handshakes.
- Invalid-output rule: whenever out_valid=0, out_insn=NOP_INSN, out_pc=0, out_ctrl=0. Downstream therefore sees Reg_WE=0 and DMEM_sel=0 in every bubble.
- States (by valid bits): EMPTY (main 0, skid 0), ONE (1,0), TWO (1,1). Main 0 with skid 1 is illegal.
- EMPTY:
  - acc -> ONE; main <= inputs.
  - else stay EMPTY.
- ONE:
  - acc & drn -> ONE; main <= inputs.
  - acc & ~drn -> TWO; skid <= inputs, main holds.
  - ~acc & drn -> EMPTY; main <= NOP/0/0.
  - neither -> hold.
- TWO:
  - in_ready=0, so no acc.
  - drn -> ONE; main <= skid, skid cleared.
  - ~drn -> hold.
- Latency and order:
  - Accept-to-out_valid is 1 cycle when EMPTY or draining.
  - Strict FIFO order; no entry dropped or duplicated except by flush.
  - Throughput is 1 transfer/cycle under continuous out_ready=1.
- Flush (flush=1 at an edge, rst=0):
  - Next state EMPTY; main and skid invalid; outputs forced to NOP/0/0.
  - in_ready=1 next cycle.
  - An acc in the flush cycle is discarded.
  - A drn in the flush cycle still completes (downstream took the entry that cycle).
  - stall_cnt is not affected by flush.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^STALL_CNT_W-1; no wrap.
  - Cleared only by rst.
- skid_full = skid_valid, registered; equals ~in_ready.
- Input values are sampled only on acc; inputs while in_ready=0 or in_valid=0 are ignored.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_insn=32'h00000013, out_pc=0, out_ctrl=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1; push insn 0x00A00093/pc 4, 0x00B00113/pc 8, 0x002081B3/pc 12 on consecutive cycles -> each appears 1 cycle later in order; skid_full stays 0.
- Backpressure: out_ready=0; push A, B -> main=A, skid=B, in_ready=0 next cycle; further in_valid ignored. Then out_ready=1 -> A out, then B; in_ready returns to 1 one cycle after A drains; stall_cnt equals the stalled cycles (e.g. 3).
- Flush in TWO: fill A, B, then flush=1 with in_valid=1 (C) -> next cycle out_valid=0, skid_full=0, in_ready=1, outputs NOP/0/0; C never appears.
- Simultaneous accept/drain in ONE: main=A, out_ready=1, push B same cycle -> next cycle out=B, state ONE, skid_full=0.
- Saturation: STALL_CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15; rst -> 0.

Source files
------------

// File: rtl/stage_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, valid/ready handshakes,
// flush-to-bubble and a saturating downstream stall counter.
module stage_skid_reg #(
  parameter int                INSN_W      = 32,
  parameter int                PC_W        = 14,
  parameter int                CTRL_W      = 13,
  parameter logic [INSN_W-1:0] NOP_INSN    = 32'h00000013,
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSN_W-1:0]      in_insn,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSN_W-1:0]      out_insn,
  output logic [PC_W-1:0]        out_pc,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic                   skid_full,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_r, state_s;
  logic   acc_s, drn_s;

  logic [INSN_W-1:0] main_insn_r, main_insn_s, skid_insn_r, skid_insn_s;
  logic [PC_W-1:0]   main_pc_r, main_pc_s, skid_pc_r, skid_pc_s;
  logic [CTRL_W-1:0] main_ctrl_r, main_ctrl_s, skid_ctrl_r, skid_ctrl_s;

  logic out_valid_r, in_ready_r, skid_full_r;
  logic out_valid_s, in_ready_s, skid_full_s;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  assign acc_s = in_valid & in_ready_r;
  assign drn_s = out_valid_r & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush kills both entries regardless of handshakes.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_s = acc_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (acc_s && !drn_s) begin
            state_s = ST_TWO;
          end else if (!acc_s && drn_s) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_TWO:   state_s = drn_s ? ST_ONE : ST_TWO;
        default:  state_s = ST_EMPTY;
      endcase
    end
  end

  // Handshake flags decoded from the upcoming state so they leave registered.
  always_comb begin
    out_valid_s = 1'b0;
    in_ready_s  = 1'b1;
    skid_full_s = 1'b0;
    case (state_s)
      ST_EMPTY: begin
        out_valid_s = 1'b0;
        in_ready_s  = 1'b1;
        skid_full_s = 1'b0;
      end
      ST_ONE: begin
        out_valid_s = 1'b1;
        in_ready_s  = 1'b1;
        skid_full_s = 1'b0;
      end
      ST_TWO: begin
        out_valid_s = 1'b1;
        in_ready_s  = 1'b0;
        skid_full_s = 1'b1;
      end
      default: begin
        out_valid_s = 1'b0;
        in_ready_s  = 1'b1;
        skid_full_s = 1'b0;
      end
    endcase
  end

  // Handshake flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      skid_full_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
      skid_full_r <= skid_full_s;
    end
  end

  // Datapath moves; an emptied main entry always reverts to the NOP bubble.
  always_comb begin
    main_insn_s = main_insn_r;
    main_pc_s   = main_pc_r;
    main_ctrl_s = main_ctrl_r;
    skid_insn_s = skid_insn_r;
    skid_pc_s   = skid_pc_r;
    skid_ctrl_s = skid_ctrl_r;
    if (flush) begin
      main_insn_s = NOP_INSN;
      main_pc_s   = '0;
      main_ctrl_s = '0;
      skid_insn_s = '0;
      skid_pc_s   = '0;
      skid_ctrl_s = '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_s) begin
            main_insn_s = in_insn;
            main_pc_s   = in_pc;
            main_ctrl_s = in_ctrl;
          end else begin
            main_insn_s = main_insn_r;
          end
        end
        ST_ONE: begin
          if (acc_s && drn_s) begin
            main_insn_s = in_insn;
            main_pc_s   = in_pc;
            main_ctrl_s = in_ctrl;
          end else if (acc_s) begin
            skid_insn_s = in_insn;
            skid_pc_s   = in_pc;
            skid_ctrl_s = in_ctrl;
          end else if (drn_s) begin
            main_insn_s = NOP_INSN;
            main_pc_s   = '0;
            main_ctrl_s = '0;
          end else begin
            main_insn_s = main_insn_r;
          end
        end
        ST_TWO: begin
          if (drn_s) begin
            main_insn_s = skid_insn_r;
            main_pc_s   = skid_pc_r;
            main_ctrl_s = skid_ctrl_r;
            skid_insn_s = '0;
            skid_pc_s   = '0;
            skid_ctrl_s = '0;
          end else begin
            main_insn_s = main_insn_r;
          end
        end
        default: begin
          main_insn_s = NOP_INSN;
          main_pc_s   = '0;
          main_ctrl_s = '0;
        end
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_insn_r <= NOP_INSN;
      main_pc_r   <= '0;
      main_ctrl_r <= '0;
      skid_insn_r <= '0;
      skid_pc_r   <= '0;
      skid_ctrl_r <= '0;
    end else begin
      main_insn_r <= main_insn_s;
      main_pc_r   <= main_pc_s;
      main_ctrl_r <= main_ctrl_s;
      skid_insn_r <= skid_insn_s;
      skid_pc_r   <= skid_pc_s;
      skid_ctrl_r <= skid_ctrl_s;
    end
  end

  // Saturating stall counter; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (out_valid_r && !out_ready && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign skid_full = skid_full_r;
  assign out_insn  = main_insn_r;
  assign out_pc    = main_pc_r;
  assign out_ctrl  = main_ctrl_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_stage_skid_reg.sv
// Bench for stage_skid_reg: directed scenarios plus random traffic checked
// against a queue-based model of the two-entry stage.
module tb_stage_skid_reg;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam int          CMAX = 65535;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, skid_full;
  logic [31:0] in_insn, out_insn;
  logic [13:0] in_pc, out_pc;
  logic [12:0] in_ctrl, out_ctrl;
  logic [15:0] stall_cnt;

  logic        s_rst, s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready, s_skid_full;
  logic [31:0] s_in_insn, s_out_insn;
  logic [13:0] s_in_pc, s_out_pc;
  logic [12:0] s_in_ctrl, s_out_ctrl;
  logic [3:0]  s_stall;

  stage_skid_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .skid_full(skid_full),
    .stall_cnt(stall_cnt)
  );

  stage_skid_reg #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_insn(s_in_insn), .in_pc(s_in_pc), .in_ctrl(s_in_ctrl), .flush(s_flush),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_insn(s_out_insn),
    .out_pc(s_out_pc), .out_ctrl(s_out_ctrl), .skid_full(s_skid_full),
    .stall_cnt(s_stall)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] q_insn[$];
  logic [13:0] q_pc[$];
  logic [12:0] q_ctrl[$];
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: an in-order queue of at most two entries.
  task automatic model_edge();
    bit vld_m, rdy_m;
    vld_m = (q_insn.size() > 0);
    rdy_m = (q_insn.size() < 2);
    if (rst) begin
      q_insn.delete(); q_pc.delete(); q_ctrl.delete();
      m_cnt = 0;
    end else begin
      if (vld_m && !out_ready && m_cnt < CMAX) m_cnt++;
      if (flush) begin
        q_insn.delete(); q_pc.delete(); q_ctrl.delete();
      end else begin
        if (vld_m && out_ready) begin
          void'(q_insn.pop_front()); void'(q_pc.pop_front()); void'(q_ctrl.pop_front());
        end
        if (in_valid && rdy_m) begin
          q_insn.push_back(in_insn); q_pc.push_back(in_pc); q_ctrl.push_back(in_ctrl);
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    bit v;
    v = (q_insn.size() > 0);
    chk({ph, "_valid"}, 64'(out_valid), 64'(v));
    chk({ph, "_in_ready"}, 64'(in_ready), 64'(q_insn.size() < 2));
    chk({ph, "_skid_full"}, 64'(skid_full), 64'(q_insn.size() == 2));
    chk({ph, "_insn"}, 64'(out_insn), v ? 64'(q_insn[0]) : 64'(NOP));
    chk({ph, "_pc"}, 64'(out_pc), v ? 64'(q_pc[0]) : 64'd0);
    chk({ph, "_ctrl"}, 64'(out_ctrl), v ? 64'(q_ctrl[0]) : 64'd0);
    chk({ph, "_stall"}, 64'(stall_cnt), 64'(m_cnt));
  endtask

  task automatic step(input bit iv, input logic [31:0] insn, input logic [13:0] pc,
                      input logic [12:0] ctrl, input bit ordy, input bit fl, input bit r,
                      input string ph);
    in_valid = iv; in_insn = insn; in_pc = pc; in_ctrl = ctrl;
    out_ready = ordy; flush = fl; rst = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(ph);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_insn = '0; in_pc = '0; in_ctrl = '0;
    flush = 1'b0; out_ready = 1'b0;
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_insn = 32'h00A00093; s_in_pc = 14'd4;
    s_in_ctrl = 13'h1FF; s_flush = 1'b0; s_out_ready = 1'b0;

    // Reset held two cycles with in_valid asserted
    step(1'b1, 32'hDEADBEEF, 14'd100, 13'h1AB, 1'b1, 1'b0, 1'b1, "rst");
    step(1'b1, 32'hDEADBEEF, 14'd100, 13'h1AB, 1'b1, 1'b0, 1'b1, "rst");
    chk("rst_insn_const", 64'(out_insn), 64'h13);
    chk("rst_stall_const", 64'(stall_cnt), 64'd0);

    // Streaming at full rate
    step(1'b1, 32'h00A00093, 14'd4,  13'h011, 1'b1, 1'b0, 1'b0, "stream");
    chk("stream_first", 64'(out_insn), 64'h00A00093);
    step(1'b1, 32'h00B00113, 14'd8,  13'h022, 1'b1, 1'b0, 1'b0, "stream");
    step(1'b1, 32'h002081B3, 14'd12, 13'h033, 1'b1, 1'b0, 1'b0, "stream");
    chk("stream_third", 64'(out_pc), 64'd12);
    step(1'b0, 32'h0, 14'd0, 13'h0, 1'b1, 1'b0, 1'b0, "stream");

    // Backpressure: A, B fill both entries, C ignored
    step(1'b1, 32'hAAAA0001, 14'd16, 13'h101, 1'b0, 1'b0, 1'b0, "bp");
    step(1'b1, 32'hBBBB0002, 14'd20, 13'h102, 1'b0, 1'b0, 1'b0, "bp");
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    step(1'b1, 32'hCCCC0003, 14'd24, 13'h103, 1'b0, 1'b0, 1'b0, "bp");
    step(1'b0, 32'h0, 14'd0, 13'h0, 1'b0, 1'b0, 1'b0, "bp");
    chk("bp_stall_3", 64'(stall_cnt), 64'd3);
    step(1'b0, 32'h0, 14'd0, 13'h0, 1'b1, 1'b0, 1'b0, "bp_drain");
    chk("bp_second_out", 64'(out_insn), 64'hBBBB0002);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    step(1'b0, 32'h0, 14'd0, 13'h0, 1'b1, 1'b0, 1'b0, "bp_drain");

    // Flush with both entries held and a concurrent push
    step(1'b1, 32'hAAAA0011, 14'd28, 13'h111, 1'b0, 1'b0, 1'b0, "fl");
    step(1'b1, 32'hBBBB0012, 14'd32, 13'h112, 1'b0, 1'b0, 1'b0, "fl");
    step(1'b1, 32'hCCCC0013, 14'd36, 13'h113, 1'b0, 1'b1, 1'b0, "fl");
    chk("fl_valid_low", 64'(out_valid), 64'd0);
    chk("fl_nop", 64'(out_insn), 64'h13);
    step(1'b0, 32'h0, 14'd0, 13'h0, 1'b1, 1'b0, 1'b0, "fl_after");

    // Simultaneous accept and drain in ONE
    step(1'b1, 32'hAAAA0021, 14'd40, 13'h121, 1'b1, 1'b0, 1'b0, "sim");
    step(1'b1, 32'hBBBB0022, 14'd44, 13'h122, 1'b1, 1'b0, 1'b0, "sim");
    chk("sim_out_b", 64'(out_insn), 64'hBBBB0022);
    chk("sim_no_skid", 64'(skid_full), 64'd0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 14'($urandom), 13'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 149) == 0), "rand");
    end

    // Saturation on the 4-bit counter instance
    s_rst = 1'b0; s_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    s_in_valid = 1'b0;
    chk("sat_valid", 64'(s_out_valid), 64'd1);
    chk("sat_start", 64'(s_stall), 64'd0);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      chk("sat_cnt", 64'(s_stall), 64'((i < 15) ? i : 15));
    end
    s_rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("sat_rst", 64'(s_stall), 64'd0);
    chk("sat_rst_valid", 64'(s_out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
